// File: rtl/fetch_buffer_if.sv
// Fetch-packet input and decode-side output bundle of the instruction fetch buffer.
interface fetch_buffer_if;
    logic        flush_i;
    logic [1:0]  in_valid_i;
    logic [31:0] in_pc_i;
    logic [63:0] in_inst_i;
    logic        in_taken_i;
    logic [29:0] in_npc_i;
    logic        in_ready_o;
    logic [1:0]  out_valid_o;
    logic [63:0] out_pc_o;
    logic [63:0] out_inst_o;
    logic [1:0]  out_taken_o;
    logic [59:0] out_npc_o;
    logic        out_ready_i;

    modport slave (
        input  flush_i, in_valid_i, in_pc_i, in_inst_i, in_taken_i, in_npc_i, out_ready_i,
        output in_ready_o, out_valid_o, out_pc_o, out_inst_o, out_taken_o, out_npc_o
    );

    modport master (
        output flush_i, in_valid_i, in_pc_i, in_inst_i, in_taken_i, in_npc_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_pc_o, out_inst_o, out_taken_o, out_npc_o
    );
endinterface

// File: rtl/fetch_buffer.sv
// Instruction fetch queue: compacts 2-wide fetch packets into a circular FIFO and
// presents up to two in-order instructions per cycle to decode.
module fetch_buffer #(
    parameter int unsigned DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_buffer_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        logic [29:0] pc;
        logic [31:0] inst;
        logic        taken;
        logic [29:0] npc;
    } entry_t;

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [PW-1:0]   head1, tail1;
    logic [CW-1:0]   count_q, count_d;
    logic            in_ready;
    logic [1:0]      out_valid;
    logic [1:0]      enq_n, deq_n;
    logic [29:0]     slot0_pc, slot1_pc;
    entry_t          wr0, wr1, rd0, rd1;
    logic            unused_pc_bits;

    assign unused_pc_bits = ^bus.in_pc_i[2:0];
    assign slot0_pc  = {bus.in_pc_i[31:3], 1'b0};
    assign slot1_pc  = {bus.in_pc_i[31:3], 1'b1};
    assign head1     = head_q + PW'(1);
    assign tail1     = tail_q + PW'(1);

    // Ready depends only on registered occupancy so upstream sees no combinational path.
    assign in_ready  = count_q <= CW'(DEPTH - 2);
    assign out_valid = {count_q >= CW'(2), count_q != '0};

    // Compact valid slots; the last valid slot carries the packet prediction.
    always_comb begin
        wr0   = '0;
        wr1   = '0;
        enq_n = 2'd0;
        case (bus.in_valid_i)
            2'b01: begin
                wr0   = '{pc: slot0_pc, inst: bus.in_inst_i[31:0], taken: bus.in_taken_i, npc: bus.in_npc_i};
                enq_n = 2'd1;
            end
            2'b10: begin
                wr0   = '{pc: slot1_pc, inst: bus.in_inst_i[63:32], taken: bus.in_taken_i, npc: bus.in_npc_i};
                enq_n = 2'd1;
            end
            2'b11: begin
                wr0   = '{pc: slot0_pc, inst: bus.in_inst_i[31:0], taken: 1'b0, npc: slot1_pc};
                wr1   = '{pc: slot1_pc, inst: bus.in_inst_i[63:32], taken: bus.in_taken_i, npc: bus.in_npc_i};
                enq_n = 2'd2;
            end
            default: ;
        endcase
        if (!in_ready) begin
            enq_n = 2'd0;
        end
    end

    always_comb begin
        deq_n   = bus.out_ready_i ? (2'(out_valid[0]) + 2'(out_valid[1])) : 2'd0;
        head_d  = head_q + PW'(deq_n);
        tail_d  = tail_q + PW'(enq_n);
        count_d = count_q + CW'(enq_n) - CW'(deq_n);
        if (bus.flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage carries no reset; pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (rst_n && !bus.flush_i && (enq_n != 2'd0)) begin
            mem_q[tail_q] <= wr0;
            if (enq_n == 2'd2) begin
                mem_q[tail1] <= wr1;
            end
        end
    end

    always_comb begin
        rd0 = out_valid[0] ? mem_q[head_q] : '0;
        rd1 = out_valid[1] ? mem_q[head1]  : '0;
    end

    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = out_valid;
    assign bus.out_pc_o    = {rd1.pc, 2'b00, rd0.pc, 2'b00};
    assign bus.out_inst_o  = {rd1.inst, rd0.inst};
    assign bus.out_taken_o = {rd1.taken, rd0.taken};
    assign bus.out_npc_o   = {rd1.npc, rd0.npc};
endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: queue-based reference model plus directed literal checks.
module tb_fetch_buffer;
    localparam int DEPTH = 8;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        taken;
        logic [29:0] npc;
    } ment_t;

    logic clk;
    logic rst_n;
    logic chk_en;
    int   total;
    int   bad;
    ment_t q[$];

    fetch_buffer_if bus ();

    fetch_buffer #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: plain FIFO of instructions, updated with the architectural rules.
    always @(posedge clk) begin
        int    nd;
        bit    rdy;
        int    last;
        ment_t e;
        logic [31:0] base;
        if (!rst_n || bus.flush_i) begin
            q.delete();
        end else begin
            rdy = (DEPTH - q.size()) >= 2;
            nd  = bus.out_ready_i ? ((q.size() >= 2) ? 2 : q.size()) : 0;
            repeat (nd) void'(q.pop_front());
            if (rdy && bus.in_valid_i != 2'b00) begin
                base = bus.in_pc_i & ~32'h7;
                last = bus.in_valid_i[1] ? 1 : 0;
                for (int s = 0; s < 2; s++) begin
                    if (bus.in_valid_i[s]) begin
                        e.pc   = base + 32'(4 * s);
                        e.inst = (s == 1) ? bus.in_inst_i[63:32] : bus.in_inst_i[31:0];
                        if (s == last) begin
                            e.taken = bus.in_taken_i;
                            e.npc   = bus.in_npc_i;
                        end else begin
                            e.taken = 1'b0;
                            e.npc   = 30'((e.pc >> 2) + 32'd1);
                        end
                        q.push_back(e);
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        ment_t e0;
        ment_t e1;
        int    n;
        if (chk_en) begin
            n  = q.size();
            e0 = (n >= 1) ? q[0] : '0;
            e1 = (n >= 2) ? q[1] : '0;
            chk("out_valid", 64'(bus.out_valid_o), 64'({n >= 2, n >= 1}));
            chk("in_ready",  64'(bus.in_ready_o),  64'((DEPTH - n) >= 2));
            chk("out_pc",    bus.out_pc_o,         {e1.pc, e0.pc});
            chk("out_inst",  bus.out_inst_o,       {e1.inst, e0.inst});
            chk("out_taken", 64'(bus.out_taken_o), 64'({e1.taken, e0.taken}));
            chk("out_npc",   64'(bus.out_npc_o),   64'({e1.npc, e0.npc}));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pkt(input logic [1:0] v, input logic [31:0] pc, input logic tk,
                       input logic [29:0] npc, input logic ordy);
        logic [31:0] base;
        base           = pc & ~32'h7;
        bus.in_valid_i  = v;
        bus.in_pc_i     = pc;
        bus.in_inst_i   = {(base + 32'h4) ^ 32'hC0DE0000, base ^ 32'hC0DE0000};
        bus.in_taken_i  = tk;
        bus.in_npc_i    = npc;
        bus.out_ready_i = ordy;
    endtask

    task automatic idle(input logic ordy, input int n);
        pkt(2'b00, 32'h0, 1'b0, 30'h0, ordy);
        repeat (n) step();
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        chk_en = 1'b0;
        rst_n  = 1'b0;
        bus.flush_i = 1'b0;
        pkt(2'b00, 32'h0, 1'b0, 30'h0, 1'b0);
        step();
        rst_n  = 1'b1;
        chk_en = 1'b1;
        chk("rst_valid", 64'(bus.out_valid_o), 64'h0);
        chk("rst_ready", 64'(bus.in_ready_o), 64'h1);
        chk("rst_pc",    bus.out_pc_o, 64'h0);

        // Three full packets, no dequeue: six entries, still ready.
        pkt(2'b11, 32'h1C000000, 1'b0, 30'h07000002, 1'b0); step();
        pkt(2'b11, 32'h1C000008, 1'b0, 30'h07000004, 1'b0); step();
        pkt(2'b11, 32'h1C000010, 1'b0, 30'h07000006, 1'b0); step();
        chk("fill6_pc",    bus.out_pc_o, {32'h1C000004, 32'h1C000000});
        chk("fill6_ready", 64'(bus.in_ready_o), 64'h1);
        pkt(2'b11, 32'h1C000018, 1'b0, 30'h07000008, 1'b0); step();
        chk("full_ready", 64'(bus.in_ready_o), 64'h0);
        pkt(2'b11, 32'h1C000020, 1'b1, 30'h0700000A, 1'b0); step();
        chk("full_hold_pc", bus.out_pc_o, {32'h1C000004, 32'h1C000000});
        chk("full_hold_ready", 64'(bus.in_ready_o), 64'h0);
        idle(1'b1, 4);
        chk("drained", 64'(bus.out_valid_o), 64'h0);

        // Single slot1 packet keeps the packet prediction.
        pkt(2'b10, 32'h1C000004, 1'b1, 30'h07000040, 1'b0); step();
        pkt(2'b00, 32'h0, 1'b0, 30'h0, 1'b0);
        chk("s1_valid", 64'(bus.out_valid_o), 64'h1);
        chk("s1_pc",    bus.out_pc_o, 64'h1C000004);
        chk("s1_inst",  64'(bus.out_inst_o[31:0]), 64'hDCDE0004);
        chk("s1_taken", 64'(bus.out_taken_o), 64'h1);
        chk("s1_npc",   64'(bus.out_npc_o[29:0]), 64'h07000040);
        idle(1'b1, 1);

        // Two-slot packet: only the last slot is tagged taken.
        pkt(2'b11, 32'h00002000, 1'b1, 30'h100, 1'b0); step();
        pkt(2'b00, 32'h0, 1'b0, 30'h0, 1'b0);
        chk("d_valid", 64'(bus.out_valid_o), 64'h3);
        chk("d_pc",    bus.out_pc_o, {32'h00002004, 32'h00002000});
        chk("d_taken", 64'(bus.out_taken_o), 64'h2);
        chk("d_npc",   64'(bus.out_npc_o), 64'({30'h100, 30'h801}));
        idle(1'b1, 1);

        // Saturate, then stream two-wide with dequeue; pointers wrap many times.
        for (int i = 0; i < 4; i++) begin
            pkt(2'b11, 32'h4000 + 32'(8 * i), 1'b0, 30'h0, 1'b0); step();
        end
        for (int i = 0; i < 20; i++) begin
            pkt(2'b11, 32'h5000 + 32'(8 * i), 1'(i), 30'(i + 32'h300), 1'b1); step();
        end
        for (int i = 0; i < 16; i++) begin
            pkt(2'(i), 32'h5800 + 32'(8 * i), 1'(i >> 1), 30'(i + 32'h500), 1'((i % 3) != 0)); step();
        end
        idle(1'b1, 6);

        // Flush at occupancy five with a concurrent packet and dequeue.
        pkt(2'b11, 32'h6000, 1'b0, 30'h0, 1'b0); step();
        pkt(2'b11, 32'h6008, 1'b0, 30'h0, 1'b0); step();
        pkt(2'b01, 32'h6010, 1'b1, 30'h1234, 1'b0); step();
        chk("pre_flush_valid", 64'(bus.out_valid_o), 64'h3);
        bus.flush_i = 1'b1;
        pkt(2'b11, 32'h6018, 1'b0, 30'h0, 1'b1); step();
        bus.flush_i = 1'b0;
        chk("flush_valid", 64'(bus.out_valid_o), 64'h0);
        chk("flush_ready", 64'(bus.in_ready_o), 64'h1);
        pkt(2'b01, 32'h7000, 1'b0, 30'h55, 1'b0); step();
        pkt(2'b00, 32'h0, 1'b0, 30'h0, 1'b0);
        chk("post_flush_pc",    bus.out_pc_o, 64'h7000);
        chk("post_flush_valid", 64'(bus.out_valid_o), 64'h1);
        idle(1'b1, 1);

        // Reset mid-stream at occupancy four.
        pkt(2'b11, 32'h8000, 1'b0, 30'h0, 1'b0); step();
        pkt(2'b11, 32'h8008, 1'b0, 30'h0, 1'b0); step();
        rst_n = 1'b0;
        pkt(2'b11, 32'h8010, 1'b1, 30'h0, 1'b1); step();
        rst_n = 1'b1;
        pkt(2'b00, 32'h0, 1'b0, 30'h0, 1'b0);
        chk("mrst_valid", 64'(bus.out_valid_o), 64'h0);
        chk("mrst_pc",    bus.out_pc_o, 64'h0);
        chk("mrst_inst",  bus.out_inst_o, 64'h0);
        chk("mrst_npc",   64'(bus.out_npc_o), 64'h0);
        chk("mrst_ready", 64'(bus.in_ready_o), 64'h1);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
